// File: rtl/cfg_seq_pkg.sv
// cfg_seq_pkg: shared FSM state encoding for the configuration-load sequencer.
package cfg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cfg_seq_cnt.sv
// cfg_seq_cnt: loadable, enable-gated modulo-DEPTH pointer with a pass counter
// and terminal-count flag (counter has reached the latched length).
module cfg_seq_cnt
  import cfg_seq_pkg::*;
#(
  parameter int unsigned PTR_W = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             restart,
  input  logic             en,
  input  logic [PTR_W-1:0] load_ptr,
  input  logic [PTR_W-1:0] load_len,
  output logic [PTR_W-1:0] ptr,
  output logic             tc
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cnt_q;
  logic [PTR_W-1:0] len_q;
  logic [PTR_W-1:0] base_q;

  // Pointer/counter update: load beats restart beats advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      base_q <= '0;
    end else if (load) begin
      ptr_q  <= load_ptr;
      base_q <= load_ptr;
      len_q  <= load_len;
      cnt_q  <= '0;
    end else if (restart) begin
      ptr_q <= base_q;
      cnt_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == LAST_PTR) ? '0 : ptr_q + ONE;
      cnt_q <= cnt_q + ONE;
    end
  end

  assign ptr = ptr_q;
  assign tc  = (cnt_q == len_q);

endmodule

// File: rtl/cfg_seq.sv
// cfg_seq: walks a configuration pointer from base over len+1 words (mod DEPTH),
// handing each word to a consumer with a valid/ready handshake.
// Optional feature: define CFG_SEQ_LOOP_EN to add the loop input, which repeats
// the pass back-to-back until abort.
module cfg_seq
  import cfg_seq_pkg::*;
#(
  parameter int unsigned PTR_W = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PTR_W-1:0] base,
  input  logic [PTR_W-1:0] len,
  input  logic             abort,
`ifdef CFG_SEQ_LOOP_EN
  input  logic             loop,
`endif
  output logic [PTR_W-1:0] ptr,
  output logic             ptr_valid,
  input  logic             ptr_ready,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic             err
);

  // One extra bit so the range check never collapses to a constant compare.
  localparam logic [PTR_W:0] MAX_IDX = (PTR_W + 1)'(DEPTH - 1);

  state_t state, state_nxt;
  logic   done_q, err_q;
  logic   done_set, err_set;
  logic   load, restart, en;
  logic   tc;
  logic   bad_req;
  logic   loop_q;

  assign bad_req = ({1'b0, base} > MAX_IDX) || ({1'b0, len} > MAX_IDX);

`ifdef CFG_SEQ_LOOP_EN
  // Loop mode is captured alongside base/len for the whole sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      loop_q <= 1'b0;
    else if (load)
      loop_q <= loop;
  end
`else
  assign loop_q = 1'b0;
`endif

  // State register plus the registered done/err pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_set;
      err_q  <= err_set;
    end
  end

  // Next-state and counter control; abort overrides both start and handshake.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    restart   = 1'b0;
    en        = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (bad_req) begin
            err_set = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (ptr_ready) begin
          if (!tc) begin
            en = 1'b1;
          end else begin
            done_set = 1'b1;
            if (loop_q)
              restart = 1'b1;
            else
              state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  cfg_seq_cnt #(
    .PTR_W (PTR_W),
    .DEPTH (DEPTH)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .restart  (restart),
    .en       (en),
    .load_ptr (base),
    .load_len (len),
    .ptr      (ptr),
    .tc       (tc)
  );

  assign ptr_valid = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign last      = ptr_valid && tc;
  assign done      = done_q;
  assign err       = err_q;

endmodule
